// File: rtl/riscv_mem_pkg.sv
// Shared types and default widths for the unified instruction/data memory port.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } mem_owner_e;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int BE_WIDTH       = DEF_DATA_WIDTH / 8;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM stage.
// Data side has priority; a starvation counter guarantees fetch forward progress.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
  mem_owner_e       owner_reg, owner_next;
  logic             if_win;

  always_comb begin
    // Fetch only beats a data request once it has been denied STARVE_LIMIT cycles in a row.
    if_win    = if_req & (~d_req | (starve_cnt_reg == CNT_MAX));
    if_gnt    = if_win;
    d_gnt     = d_req & ~if_win;

    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_win) begin
      mem_en   = 1'b1;
      mem_be   = '1;
      mem_addr = if_addr;
    end else if (d_req) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end

    starve_cnt_next = starve_cnt_reg;
    if (!if_req || if_win) begin
      starve_cnt_next = '0;
    end else if (starve_cnt_reg != CNT_MAX) begin
      starve_cnt_next = starve_cnt_reg + CNT_W'(1);
    end

    // Stores return nothing, so only reads claim next cycle's response slot.
    owner_next = OWN_NONE;
    if (if_win) begin
      owner_next = OWN_IF;
    end else if (d_req && !d_we) begin
      owner_next = OWN_D;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_reg      <= OWN_NONE;
      starve_cnt_reg <= '0;
    end else begin
      owner_reg      <= owner_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  assign if_rvalid = (owner_reg == OWN_IF);
  assign d_rvalid  = (owner_reg == OWN_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a word-array reference model and a denied-cycle arbitration rule.
module tb_mem_port_arbiter;

  localparam int SL = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_if;
    logic [31:0] data;
    int          due;
  } resp_t;

  resp_t       exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [31:0] env_mem [16384];
  logic [31:0] ref_mem [16384];

  function automatic logic [31:0] init_word(input int idx);
    logic [15:0] a;
    a = 16'(idx);
    return {a ^ 16'hC3A5, ~a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                      input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd);
    @(posedge clock);
    #1;
    if_req = ir; if_addr = ia;
    d_req = dr; d_we = dwe; d_be = dbe; d_addr = da; d_wdata = dwd;
    @(negedge clock);
    $display("cyc %0d: if_req=%0b d_req=%0b we=%0b -> if_gnt=%0b d_gnt=%0b mem_addr=%h",
             cyc, ir, dr, dwe, if_gnt, d_gnt, mem_addr);
  endtask

  function automatic string gchar();
    return if_gnt ? "I" : (d_gnt ? "D" : "-");
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h100 + 32'($urandom_range(0, 31)) * 4;
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Behavioural memory: samples the request mid-cycle, performs it at the edge.
  initial begin
    logic        l_en, l_we;
    logic [3:0]  l_be;
    logic [31:0] l_addr, l_wd;
    l_en = 1'b0; l_we = 1'b0; l_be = '0; l_addr = '0; l_wd = '0;
    forever begin
      @(negedge clock);
      l_en = mem_en; l_we = mem_we; l_be = mem_be; l_addr = mem_addr; l_wd = mem_wdata;
      @(posedge clock);
      if (l_en) begin
        if (l_we) env_mem[l_addr[15:2]] = merge(env_mem[l_addr[15:2]], l_wd, l_be);
        else      mem_rdata = env_mem[l_addr[15:2]];
      end
    end
  end

  // Reference model: predicts grants, memory drive and the response each grant owes.
  initial begin
    int          if_wait;
    logic        e_if, e_d, p_valid;
    logic        p_if_req, p_if_gnt, p_d_req, p_d_gnt, p_d_we;
    logic [3:0]  p_d_be;
    logic [31:0] p_if_addr, p_d_addr, p_d_wd;
    if_wait = 0; p_valid = 1'b0;
    p_if_req = 0; p_if_gnt = 0; p_d_req = 0; p_d_gnt = 0; p_d_we = 0;
    p_d_be = '0; p_if_addr = '0; p_d_addr = '0; p_d_wd = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        if_wait = 0;
        p_valid = 1'b0;
      end else begin
        e_if = if_req && (!d_req || if_wait >= SL);
        e_d  = d_req && !e_if;
        chk("if_gnt", if_gnt, e_if);
        chk("d_gnt", d_gnt, e_d);
        if (e_if) begin
          chk("mem_ctl", {mem_en, mem_we, mem_be}, {1'b1, 1'b0, 4'hF});
          chk("mem_addr", mem_addr, if_addr);
          exp_q.push_back('{1'b1, ref_mem[if_addr[15:2]], cyc + 1});
        end else if (e_d) begin
          chk("mem_ctl", {mem_en, mem_we, mem_be}, {1'b1, d_we, d_be});
          chk("mem_addr", mem_addr, d_addr);
          chk("mem_wdata", mem_wdata, d_wdata);
          if (d_we) ref_mem[d_addr[15:2]] = merge(ref_mem[d_addr[15:2]], d_wdata, d_be);
          else      exp_q.push_back('{1'b0, ref_mem[d_addr[15:2]], cyc + 1});
        end else begin
          chk("mem_ctl", {mem_en, mem_we, mem_be}, 6'd0);
          chk("mem_addr", mem_addr, 32'd0);
          chk("mem_wdata", mem_wdata, 32'd0);
        end
        if_wait = (if_req && !e_if) ? if_wait + 1 : 0;
        if (p_valid && p_if_req && !p_if_gnt) begin
          n_cmp++;
          assert (if_req && if_addr == p_if_addr) else begin
            n_bad++;
            $display("FAIL if_hold: got req=%0b addr=%h required req=1 addr=%h", if_req, if_addr, p_if_addr);
          end
        end
        if (p_valid && p_d_req && !p_d_gnt) begin
          n_cmp++;
          assert (d_req && d_we == p_d_we && d_be == p_d_be && d_addr == p_d_addr && d_wdata == p_d_wd) else begin
            n_bad++;
            $display("FAIL d_hold: got req=%0b addr=%h required req=1 addr=%h", d_req, d_addr, p_d_addr);
          end
        end
        p_valid = 1'b1;
        p_if_req = if_req; p_if_gnt = if_gnt; p_if_addr = if_addr;
        p_d_req = d_req; p_d_gnt = d_gnt; p_d_we = d_we; p_d_be = d_be;
        p_d_addr = d_addr; p_d_wd = d_wdata;
      end
    end
  end

  // Monitor: every response must match the oldest expectation, due exactly one cycle after its grant.
  initial forever begin
    resp_t e;
    @(posedge clock);
    #2;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL stale_resp: expected response due cycle %0d never checked", exp_q[0].due);
      void'(exp_q.pop_front());
    end
    if (if_rvalid || d_rvalid) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        chk("resp_route", {if_rvalid, d_rvalid}, e.is_if ? 2'b10 : 2'b01);
        chk("resp_data", e.is_if ? if_rdata : d_rdata, e.data);
      end else begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_resp: got if_rvalid=%0b d_rvalid=%0b expected none (cycle %0d)",
                 if_rvalid, d_rvalid, cyc);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL missing_resp: got no rvalid expected %s response (cycle %0d)",
               exp_q[0].is_if ? "IF" : "D", cyc);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string pat;
    logic  ir, dr, dwe, gi, gd;
    logic [3:0]  dbe;
    logic [31:0] ia, da, dwd;

    for (int i = 0; i < 16384; i++) begin
      env_mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    env_mem[0] = 32'h00A00513;         ref_mem[0] = 32'h00A00513;
    env_mem[32'h2000 >> 2] = 32'h11223344; ref_mem[32'h2000 >> 2] = 32'h11223344;

    // Reset and idle
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_rvalid", {if_rvalid, d_rvalid}, 2'b00);
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("idle_ctl", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, mem_be}, 10'd0);
      chk("idle_addr", mem_addr, 32'd0);
      chk("idle_wdata", mem_wdata, 32'd0);
    end

    // First fetch
    step(1, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("fetch_gnt", if_gnt, 1'b1);
    step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("fetch_rvalid", if_rvalid, 1'b1);
    chk("fetch_rdata", if_rdata, 32'h00A00513);

    // Both requesting continuously
    pat = "";
    for (int i = 0; i < 10; i++) begin
      step(1, 32'h40, 1, 0, 4'hF, 32'h1000, 32'h0);
      pat = {pat, gchar()};
    end
    chk_str("contention_pattern", pat, "DDDDIDDDDI");
    step(0, 32'h0, 1, 0, 4'hF, 32'h1000, 32'h0);
    step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Store then load, same word
    step(0, 32'h0, 1, 1, 4'hF, 32'h1000, 32'hDEADBEEF);
    chk("store_gnt", d_gnt, 1'b1);
    step(0, 32'h0, 1, 0, 4'hF, 32'h1000, 32'h0);
    chk("store_no_rvalid", d_rvalid, 1'b0);
    step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("load_rvalid", d_rvalid, 1'b1);
    chk("load_rdata", d_rdata, 32'hDEADBEEF);

    // Byte-lane store
    step(0, 32'h0, 1, 1, 4'h2, 32'h2000, 32'h0000AB00);
    chk("byte_mem_be", {mem_we, mem_be}, {1'b1, 4'h2});
    step(0, 32'h0, 1, 0, 4'hF, 32'h2000, 32'h0);
    step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("byte_rdata", d_rdata, 32'h1122AB44);

    // Reset while a response is visible and another is in flight
    step(1, 32'h4, 0, 0, 4'h0, 32'h0, 32'h0);
    step(1, 32'h8, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("pre_reset_rvalid", if_rvalid, 1'b1);
    #1;
    reset = 1'b1; if_req = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rvalid_drop", {if_rvalid, d_rvalid}, 2'b00);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    if_req = 1'b1; if_addr = 32'hC;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h1000; d_wdata = 32'h0;
    @(negedge clock);
    pat = gchar();
    for (int i = 0; i < 4; i++) begin
      step(1, 32'hC, 1, 0, 4'hF, 32'h1000, 32'h0);
      pat = {pat, gchar()};
    end
    chk_str("post_reset_pattern", pat, "DDDDI");
    step(0, 32'h0, 1, 0, 4'hF, 32'h1000, 32'h0);
    step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Alternating single requesters are never delayed
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) step(1, rand_addr(), 0, 0, 4'h0, 32'h0, 32'h0);
      else            step(0, 32'h0, 1, 1'($urandom % 2), 4'($urandom_range(1, 15)), rand_addr(), $urandom);
      chk("alt_immediate", (i % 2 == 0) ? if_gnt : d_gnt, 1'b1);
    end
    step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Randomized traffic; requesters hold until granted
    ir = 0; dr = 0; dwe = 0; dbe = 4'hF; ia = '0; da = '0; dwd = '0; gi = 0; gd = 0;
    for (int i = 0; i < 500; i++) begin
      if (!ir || gi) begin
        ir = ($urandom % 3) != 0;
        ia = rand_addr();
      end
      if (!dr || gd) begin
        dr  = 1'($urandom % 2);
        dwe = 1'($urandom % 2);
        dbe = 4'($urandom_range(1, 15));
        da  = rand_addr();
        dwd = $urandom;
      end
      step(ir, ia, dr, dwe, dbe, da, dwd);
      gi = if_gnt;
      gd = d_gnt;
    end
    // Let any pending request drain, then go idle
    while ((ir && !gi) || (dr && !gd)) begin
      step(ir && !gi, ia, dr && !gd, dwe, dbe, da, dwd);
      if (ir && !gi) gi = if_gnt;
      if (dr && !gd) gd = d_gnt;
    end
    repeat (3) step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
